mix_scheduler: RTL
==================

MIX_SCHEDULER -- requirements
Module: mix_scheduler

Interface
REQ-001 Parameter MIX_LATENCY, default 2, SHALL give the mixer pipeline depth in clk cycles (legal 1-15).
REQ-002 Parameter VOICE_TIMEOUT, default 32, SHALL give the cycles to wait for a voice before substituting silence (legal 1-255).
REQ-003 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 sample_tick  input  1  one-cycle pulse at audio frame rate.
REQ-006 voice_req  input  4  bit i high: voice i presents a sample.
REQ-007 voice_data  input  32  packed samples {v3,v2,v1,v0}, 8 bits each, unsigned.
REQ-008 voice_ack  output  4  one-hot; bit i high: voice i sample consumed this cycle.
REQ-009 mute  input  4  bit i high: voice i forced to silence.
REQ-010 audio0, audio1, audio2, audio3  output  8 each  registered voice samples driven to the mixer.
REQ-011 mix_down  input  32  mixer result.
REQ-012 out_data  output  32  captured mix result.
REQ-013 out_valid  output  1  out_data valid.
REQ-014 out_ready  input  1  downstream accepts out_data.
REQ-015 busy  output  1  high whenever state is not IDLE.
REQ-016 tick_miss  output  1  one-cycle pulse: sample_tick dropped.

Function
REQ-017 States SHALL be IDLE, GATHER, MIX and OUT.
REQ-018 IDLE: sample_tick SHALL move to GATHER, clear voice pointer to 0, clear wait counter, and register mute into mute_q.
REQ-019 GATHER, pointer i, mute_q[i]=1: audio_i SHALL load 8'h00 and the pointer SHALL advance; voice_ack SHALL stay 0.
REQ-020 GATHER, pointer i, mute_q[i]=0, voice_req[i]=1: voice_ack[i] SHALL be high combinationally that cycle, audio_i SHALL load voice_data[8i+7:8i] on the edge, and the pointer SHALL advance.
REQ-021 GATHER, pointer i, mute_q[i]=0, voice_req[i]=0: the wait counter SHALL increment; when it reaches VOICE_TIMEOUT, audio_i SHALL load 8'h00, the pointer SHALL advance and the counter SHALL clear.
REQ-022 Each voice SHALL take at least one cycle; the wait counter SHALL clear on every pointer advance.
REQ-023 After voice 3 advances, state SHALL enter MIX for exactly MIX_LATENCY cycles; on the final MIX cycle out_data SHALL load mix_down and state SHALL enter OUT.
REQ-024 OUT: out_valid SHALL be 1 and out_data SHALL be held stable until out_valid&out_ready.
REQ-025 Handshake cycle with sample_tick=1: state SHALL go directly to GATHER (pointer 0, mute re-registered), out_valid SHALL drop, and tick_miss SHALL stay 0.
REQ-026 Handshake cycle without sample_tick: state SHALL return to IDLE.
REQ-027 sample_tick in GATHER, MIX, or OUT without handshake SHALL be dropped with tick_miss pulsed for that one cycle; the current frame SHALL be unaffected.
REQ-028 audio0-3 SHALL hold values between frames; voice_ack SHALL be 0 outside GATHER.
REQ-029 Changes to mute after the accepting tick SHALL not affect the current frame.

Reset
REQ-030 reset SHALL force state IDLE, pointer and counters 0, and mute_q 0.
REQ-031 reset SHALL force audio0-3, out_data, and underrun_cnt to 0, and out_valid, busy, tick_miss, and voice_ack to 0.
REQ-032 reset asserted mid-frame SHALL abandon the frame; no ack or out_valid SHALL be issued for it.
REQ-033 reset SHALL dominate sample_tick and out_ready in the same cycle.

Configuration
REQ-034 With MIX_SCHEDULER_UNDERRUN_CNT_EN defined, a 16-bit output underrun_cnt SHALL exist, increment by 1 on each REQ-021 timeout, and saturate at 16'hFFFF.
REQ-035 Without MIX_SCHEDULER_UNDERRUN_CNT_EN, the port and counter SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-036 All voice_req=1, voice_data=32'h40302010, mute=0, tick -> acks 0001,0010,0100,1000 on consecutive cycles; audio0-3 equal 10,20,30,40; out_valid exactly 4+MIX_LATENCY cycles after GATHER entry.
REQ-037 mute=4'b0101, all req=1 -> voice_ack only bits 1 and 3 pulse; audio0=audio2=8'h00.
REQ-038 voice_req[2]=0 throughout -> audio2=8'h00 after 32 cycles on voice 2; underrun_cnt=1 when the macro is defined.
REQ-039 out_ready held 0 for 10 cycles with a tick in between -> out_data stable, tick_miss one pulse; tick coincident with the handshake -> immediate GATHER, no tick_miss.
REQ-040 reset during GATHER on voice 2 -> next cycle all outputs 0, state IDLE; the following tick runs a full clean frame.

Source files
------------

// File: rtl/mix_scheduler.sv
// mix_scheduler: gathers one sample per voice each audio frame, waits out the mixer
// pipeline, then holds the mix result for downstream. Define MIX_SCHEDULER_UNDERRUN_CNT_EN for underrun_cnt.
module mix_scheduler #(
    parameter int MIX_LATENCY   = 2,
    parameter int VOICE_TIMEOUT = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sample_tick,
    input  logic [3:0]  voice_req,
    input  logic [31:0] voice_data,
    output logic [3:0]  voice_ack,
    input  logic [3:0]  mute,
    output logic [7:0]  audio0,
    output logic [7:0]  audio1,
    output logic [7:0]  audio2,
    output logic [7:0]  audio3,
    input  logic [31:0] mix_down,
    output logic [31:0] out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        busy,
    output logic        tick_miss
`ifdef MIX_SCHEDULER_UNDERRUN_CNT_EN
    ,
    output logic [15:0] underrun_cnt
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_GATHER = 2'd1,
        ST_MIX    = 2'd2,
        ST_OUT    = 2'd3
    } state_t;

    localparam logic [3:0] MIX_LAST  = 4'(MIX_LATENCY - 1);
    localparam logic [7:0] WAIT_LAST = 8'(VOICE_TIMEOUT - 1);

    state_t      state_r, state_s;
    logic [1:0]  ptr_r, ptr_s;
    logic [7:0]  wait_r, wait_s;
    logic [3:0]  mix_r, mix_s;
    logic [3:0]  mute_q_r, mute_q_s;
    logic [7:0]  audio_r [4];
    logic [31:0] out_data_r;
    logic        tick_miss_r;
    logic [3:0]  ack_s;
    logic        load_s;
    logic [7:0]  load_val_s;
    logic        advance_s;
    logic        miss_s;
    logic        capture_s;

    // Next-state, voice pointer/wait counter and per-cycle strobes
    always_comb begin
        state_s    = state_r;
        ptr_s      = ptr_r;
        wait_s     = wait_r;
        mix_s      = mix_r;
        mute_q_s   = mute_q_r;
        ack_s      = 4'b0000;
        load_s     = 1'b0;
        load_val_s = 8'h00;
        advance_s  = 1'b0;
        miss_s     = 1'b0;
        capture_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (sample_tick) begin
                    state_s  = ST_GATHER;
                    ptr_s    = 2'd0;
                    wait_s   = 8'd0;
                    mute_q_s = mute;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_GATHER: begin
                miss_s = sample_tick;
                if (mute_q_r[ptr_r]) begin
                    load_s    = 1'b1;
                    advance_s = 1'b1;
                end else if (voice_req[ptr_r]) begin
                    ack_s      = 4'b0001 << ptr_r;
                    load_s     = 1'b1;
                    load_val_s = voice_data[{ptr_r, 3'b000} +: 8];
                    advance_s  = 1'b1;
                end else if (wait_r == WAIT_LAST) begin
                    // voice missed its slot: substitute silence
                    load_s    = 1'b1;
                    advance_s = 1'b1;
                end else begin
                    wait_s = wait_r + 8'd1;
                end
                if (advance_s) begin
                    wait_s = 8'd0;
                    ptr_s  = ptr_r + 2'd1;
                    if (ptr_r == 2'd3) begin
                        state_s = ST_MIX;
                        mix_s   = 4'd0;
                    end else begin
                        state_s = ST_GATHER;
                    end
                end else begin
                    state_s = ST_GATHER;
                end
            end
            ST_MIX: begin
                miss_s = sample_tick;
                if (mix_r == MIX_LAST) begin
                    capture_s = 1'b1;
                    state_s   = ST_OUT;
                end else begin
                    mix_s = mix_r + 4'd1;
                end
            end
            ST_OUT: begin
                if (out_ready) begin
                    if (sample_tick) begin
                        state_s  = ST_GATHER;
                        ptr_s    = 2'd0;
                        wait_s   = 8'd0;
                        mute_q_s = mute;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end else begin
                    miss_s = sample_tick;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State, sample and result registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            ptr_r       <= 2'd0;
            wait_r      <= 8'd0;
            mix_r       <= 4'd0;
            mute_q_r    <= 4'b0000;
            audio_r[0]  <= 8'h00;
            audio_r[1]  <= 8'h00;
            audio_r[2]  <= 8'h00;
            audio_r[3]  <= 8'h00;
            out_data_r  <= 32'h0000_0000;
            tick_miss_r <= 1'b0;
        end else begin
            state_r     <= state_s;
            ptr_r       <= ptr_s;
            wait_r      <= wait_s;
            mix_r       <= mix_s;
            mute_q_r    <= mute_q_s;
            tick_miss_r <= miss_s;
            if (load_s) begin
                audio_r[ptr_r] <= load_val_s;
            end
            if (capture_s) begin
                out_data_r <= mix_down;
            end
        end
    end

`ifdef MIX_SCHEDULER_UNDERRUN_CNT_EN
    logic        timeout_s;
    logic [15:0] underrun_r;

    assign timeout_s = (state_r == ST_GATHER) && !mute_q_r[ptr_r] &&
                       !voice_req[ptr_r] && (wait_r == WAIT_LAST);

    // Saturating count of voices replaced by silence after a timeout
    always_ff @(posedge clk) begin
        if (reset) begin
            underrun_r <= 16'h0000;
        end else if (timeout_s && (underrun_r != 16'hFFFF)) begin
            underrun_r <= underrun_r + 16'd1;
        end
    end

    assign underrun_cnt = underrun_r;
`endif

    // voice_ack is a same-cycle strobe; reset blanks it immediately
    assign voice_ack = ack_s & {4{~reset}};
    assign audio0    = audio_r[0];
    assign audio1    = audio_r[1];
    assign audio2    = audio_r[2];
    assign audio3    = audio_r[3];
    assign out_data  = out_data_r;
    assign out_valid = (state_r == ST_OUT);
    assign busy      = (state_r != ST_IDLE);
    assign tick_miss = tick_miss_r;

endmodule
